// File: rtl/tape_player_if.sv
// SDRAM byte read port between the tape player (master) and the memory controller (slave).
// One request at a time: rd is held until a single-cycle valid returns the byte.
interface tape_player_if #(
  parameter int ADDR_W = 25
) ();
  logic [ADDR_W-1:0] sdram_addr;
  logic              sdram_rd;
  logic              sdram_valid;
  logic [7:0]        sdram_data;

  modport master (
    output sdram_addr,
    output sdram_rd,
    input  sdram_valid,
    input  sdram_data
  );

  modport slave (
    input  sdram_addr,
    input  sdram_rd,
    output sdram_valid,
    output sdram_data
  );
endinterface

// File: rtl/tape_player.sv
// Cassette tape streamer: prefetches a tape image from SDRAM into a small FIFO and
// shifts it out MSB-first with a programmable bit period, end-of-tape and underrun tracking.
module tape_player #(
  parameter int ADDR_W     = 25,
  parameter int FIFO_DEPTH = 8,
  parameter int BIT_TICKS  = 4,
  parameter int UNDER_W    = 8
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               ce,
  input  logic               play_tgl,
  input  logic               rewind,
  input  logic [ADDR_W-1:0]  tape_len,
  tape_player_if.master      sdram,
  output logic               data,
  output logic [2:0]         status,
  output logic [ADDR_W-1:0]  byte_pos,
  output logic [UNDER_W-1:0] underruns
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int TICK_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(BIT_TICKS - 1);
  localparam logic [PTR_W:0]    DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_EOT   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               init_q, init_d;
  logic [ADDR_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               rd_q, rd_d;
  logic               abort_q, abort_d;
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               data_q, data_d;
  logic [ADDR_W-1:0]  byte_pos_q, byte_pos_d;
  logic               started_q, started_d;
  logic [UNDER_W-1:0] under_q, under_d;

  logic [7:0] fifo_mem [FIFO_DEPTH];

  logic [ADDR_W-1:0] len_eff;
  logic [ADDR_W-1:0] next_idx;
  logic [PTR_W:0]    fifo_cnt;
  logic              fifo_empty;
  logic              fifo_full;
  logic [7:0]        fifo_head;
  logic              slot;
  logic              need_byte;
  logic              last_done;
  logic              pop_en;
  logic              push_en;
  logic              underrun_ev;
  logic              bit_adv;
  logic              req_ok;

  // The length register only loads on the first edge after reset, so the live input
  // stands in for it until then.
  assign len_eff    = init_q ? tape_len : len_q;
  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == DEPTH_C);
  assign fifo_head  = fifo_mem[rd_ptr_q[PTR_W-1:0]];

  assign slot      = (state_q == ST_PLAY) && ce && (tick_q == '0);
  assign need_byte = (bit_q == 3'd0);
  assign last_done = need_byte && started_q && (byte_pos_q == len_eff - ADDR_W'(1));
  assign next_idx  = started_q ? byte_pos_q + ADDR_W'(1) : '0;

  assign pop_en      = slot && !rewind && need_byte && !last_done && !fifo_empty;
  assign underrun_ev = slot && !rewind && need_byte && !last_done && fifo_empty
                       && (next_idx < len_eff);
  assign bit_adv     = slot && !rewind && !need_byte;

  // A byte still in flight after a rewind is dropped rather than pushed.
  assign push_en = sdram.sdram_valid && rd_q && !abort_q && !rewind;

  // With at most one read outstanding and none pending here, one free slot is enough.
  assign req_ok = !rd_q && (state_q != ST_EOT) && !rewind
                  && (fetch_addr_q < len_eff) && !fifo_full;

  // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    init_d       = 1'b0;
    len_d        = (rewind || init_q) ? tape_len : len_q;
    fetch_addr_d = fetch_addr_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    abort_d      = abort_q;
    wr_ptr_d     = wr_ptr_q + (PTR_W + 1)'(push_en);
    rd_ptr_d     = rd_ptr_q + (PTR_W + 1)'(pop_en);
    tick_d       = tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    data_d       = data_q;
    byte_pos_d   = byte_pos_q;
    started_d    = started_q;
    under_d      = under_q;

    case (state_q)
      ST_STOP:  if (play_tgl) state_d = (len_eff == '0) ? ST_EOT : ST_PLAY;
      ST_PLAY:  begin
        if (slot && last_done) state_d = ST_EOT;
        else if (play_tgl)     state_d = ST_PAUSE;
      end
      ST_PAUSE: if (play_tgl) state_d = ST_PLAY;
      default:  state_d = ST_EOT;
    endcase

    if (rd_q) begin
      if (sdram.sdram_valid) begin
        rd_d    = 1'b0;
        abort_d = 1'b0;
        if (!abort_q) fetch_addr_d = fetch_addr_q + ADDR_W'(1);
      end
    end else if (req_ok) begin
      rd_d   = 1'b1;
      addr_d = fetch_addr_q;
    end

    if ((state_q == ST_PLAY) && ce) tick_d = (tick_q == TICK_MAX) ? '0 : tick_q + TICK_W'(1);

    if (pop_en) begin
      data_d    = fifo_head[7];
      shift_d   = {fifo_head[6:0], 1'b0};
      bit_d     = 3'd1;
      started_d = 1'b1;
      if (started_q) byte_pos_d = byte_pos_q + ADDR_W'(1);
    end

    if (bit_adv) begin
      data_d  = shift_q[7];
      shift_d = {shift_q[6:0], 1'b0};
      bit_d   = bit_q + 3'd1;
    end

    if (underrun_ev && (under_q != '1)) under_d = under_q + UNDER_W'(1);

    if (slot && last_done) data_d = 1'b0;

    if (rewind) begin
      state_d      = ST_STOP;
      fetch_addr_d = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      tick_d       = '0;
      bit_d        = 3'd0;
      shift_d      = 8'h00;
      data_d       = 1'b0;
      byte_pos_d   = '0;
      started_d    = 1'b0;
      under_d      = '0;
      if (rd_q && !sdram.sdram_valid) abort_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_STOP;
      init_q       <= 1'b1;
      len_q        <= '0;
      fetch_addr_q <= '0;
      addr_q       <= '0;
      rd_q         <= 1'b0;
      abort_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tick_q       <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'h00;
      data_q       <= 1'b0;
      byte_pos_q   <= '0;
      started_q    <= 1'b0;
      under_q      <= '0;
    end else begin
      state_q      <= state_d;
      init_q       <= init_d;
      len_q        <= len_d;
      fetch_addr_q <= fetch_addr_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      abort_q      <= abort_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      byte_pos_q   <= byte_pos_d;
      started_q    <= started_d;
      under_q      <= under_d;
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk_sys) begin
    if (push_en) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= sdram.sdram_data;
  end

  assign sdram.sdram_addr = addr_q;
  assign sdram.sdram_rd   = rd_q;
  assign data             = data_q;
  assign status           = {state_q == ST_PLAY, state_q == ST_EOT, fifo_empty};
  assign byte_pos         = byte_pos_q;
  assign underruns        = under_q;

endmodule

// File: tb/tb_tape_player.sv
// Self-checking bench for tape_player: table-driven tape runs and random runs against a
// bit-stream model of the tape image, plus directed rewind, empty-tape and async-reset cases.
module tb_tape_player;
  localparam int ADDR_W = 25;
  localparam int DEPTH  = 8;
  localparam int BT     = 4;
  localparam int UW     = 8;

  typedef struct {
    int len;
    int lat;
    int prefill;
    int ce_pct;
    int pause_k;
    int pause_len;
    int under_mode;   // 0: must stay zero, 1: must be non-zero, 2: not checked
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              ce = 1'b0;
  logic              play_tgl = 1'b0;
  logic              rewind = 1'b0;
  logic [ADDR_W-1:0] tape_len = '0;
  logic              data;
  logic [2:0]        status;
  logic [ADDR_W-1:0] byte_pos;
  logic [UW-1:0]     underruns;

  tape_player_if #(.ADDR_W(ADDR_W)) bus ();

  tape_player #(
    .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .BIT_TICKS(BT), .UNDER_W(UW)
  ) dut (
    .clk_sys   (clk),
    .reset_n   (rst_n),
    .ce        (ce),
    .play_tgl  (play_tgl),
    .rewind    (rewind),
    .tape_len  (tape_len),
    .sdram     (bus.master),
    .data      (data),
    .status    (status),
    .byte_pos  (byte_pos),
    .underruns (underruns)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // SDRAM model: fixed latency, one request at a time, counts bytes that reach the FIFO.
  logic [7:0] mem [64];
  int lat = 0;
  int epoch = 0;
  int rst_epoch = 0;
  int delivered = 0;
  int rd_cycles = 0;
  int req_addr [$];

  initial begin : mem_model
    int a, ep, rep;
    bus.sdram_valid = 1'b0;
    bus.sdram_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.sdram_rd) begin
        a   = int'(bus.sdram_addr);
        ep  = epoch;
        rep = rst_epoch;
        req_addr.push_back(a);
        repeat (lat) @(negedge clk);
        if (rep == rst_epoch) begin
          bus.sdram_valid = 1'b1;
          bus.sdram_data  = mem[a[5:0]];
          @(negedge clk);
          bus.sdram_valid = 1'b0;
          if (ep == epoch && rep == rst_epoch) delivered++;
        end
      end
    end
  end

  always @(negedge clk) if (bus.sdram_rd) rd_cycles++;

  always @(negedge clk) begin
    if (rst_n && dut.push_en && dut.fifo_full) begin
      errors++;
      $display("FAIL fifo_push_when_full: got push=1 expected push=0");
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic do_rewind(input int len);
    tape_len  = ADDR_W'(len);
    rewind    = 1'b1;
    epoch++;
    delivered = 0;
    cyc();
    rewind = 1'b0;
  endtask

  // Plays one tape and compares every cycle against the expected MSB-first bit stream.
  task automatic play_tape(input vec_t v, input bit rew, input int rpause, input string tag);
    int k, total, tick, pause_left, max_cyc, under_prev, n;
    bit paused, done, last, ce_now, tgl, pause_used, exp_bit;
    total = 8 * v.len;
    k = 0; tick = 0; last = 1'b0; done = 1'b0; paused = 1'b0; pause_used = 1'b0;
    pause_left = 0;
    max_cyc = 3000 + v.len * 400;
    lat = v.lat;
    if (rew) begin
      do_rewind(v.len);
      check({tag, " rewind_status"}, status, 3'b001);
      check({tag, " rewind_byte_pos"}, byte_pos, 0);
      check({tag, " rewind_data"}, data, 0);
    end
    ce = 1'b1;
    repeat (v.prefill) cyc();
    play_tgl = 1'b1;
    cyc();
    play_tgl = 1'b0;
    under_prev = int'(underruns);
    for (n = 0; n < max_cyc && !done; n++) begin
      ce_now = ($urandom_range(99) < v.ce_pct);
      ce = ce_now;
      tgl = 1'b0;
      if (paused) begin
        pause_left--;
        if (pause_left <= 0) tgl = 1'b1;
      end else if (v.pause_k >= 0 && k == v.pause_k && !pause_used) begin
        tgl = 1'b1; pause_used = 1'b1; pause_left = v.pause_len;
      end else if (rpause > 0 && $urandom_range(999) < rpause) begin
        tgl = 1'b1; pause_left = $urandom_range(30, 1);
      end
      play_tgl = tgl;
      cyc();
      play_tgl = 1'b0;
      if (!paused && ce_now && tick == 0) begin
        if (k == total) begin
          check({tag, " eot_status"}, status, 3'b011);
          check({tag, " eot_data"}, data, 0);
          done = 1'b1;
        end else if (int'(underruns) != under_prev) begin
          check({tag, " stall_data_hold"}, data, last);
          check({tag, " stall_count_step"}, underruns, under_prev + 1);
          check({tag, " stall_legal"}, (k % 8 == 0) && (delivered <= k / 8), 1);
        end else begin
          exp_bit = mem[k / 8][7 - (k % 8)];
          check({tag, " bit"}, data, exp_bit);
          last = data;
          k++;
        end
      end else begin
        check({tag, " hold_data"}, data, last);
        check({tag, " hold_underruns"}, underruns, under_prev);
      end
      if (!paused && ce_now) tick = (tick + 1) % BT;
      under_prev = int'(underruns);
      if (tgl && !done) paused = !paused;
      check({tag, " playing_flag"}, status[2], !paused && !done);
    end
    check({tag, " reached_eot"}, done, 1);
    check({tag, " final_byte_pos"}, byte_pos, v.len - 1);
    check({tag, " final_rd_idle"}, bus.sdram_rd, 0);
    if (v.under_mode == 0) check({tag, " no_underrun"}, underruns, 0);
    if (v.under_mode == 1) check({tag, " underrun_seen"}, underruns != 0, 1);
    play_tgl = 1'b1;
    cyc();
    play_tgl = 1'b0;
    cyc();
    check({tag, " eot_ignores_play"}, status, 3'b011);
  endtask

  vec_t vecs [5];

  initial begin : main
    int n0;
    bit seen, stayed_empty;
    vec_t rv;

    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF; mem[3] = 8'h5A;
    for (int i = 4; i < 64; i++) mem[i] = 8'((i * 37 + 11) & 255);

    vecs[0] = '{len: 3,  lat: 0,  prefill: 20, ce_pct: 100, pause_k: -1, pause_len: 0,   under_mode: 0};
    vecs[1] = '{len: 4,  lat: 40, prefill: 0,  ce_pct: 100, pause_k: -1, pause_len: 0,   under_mode: 1};
    vecs[2] = '{len: 3,  lat: 2,  prefill: 20, ce_pct: 100, pause_k: 3,  pause_len: 100, under_mode: 0};
    vecs[3] = '{len: 12, lat: 3,  prefill: 10, ce_pct: 50,  pause_k: -1, pause_len: 0,   under_mode: 0};
    vecs[4] = '{len: 1,  lat: 0,  prefill: 5,  ce_pct: 100, pause_k: 7,  pause_len: 10,  under_mode: 0};

    tape_len = ADDR_W'(3);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_status", status, 3'b001);
    check("reset_data", data, 0);
    check("reset_byte_pos", byte_pos, 0);
    check("reset_underruns", underruns, 0);
    check("reset_rd", bus.sdram_rd, 0);
    check("reset_addr", bus.sdram_addr, 0);
    @(negedge clk) rst_n = 1'b1;
    cyc();

    foreach (vecs[i]) play_tape(vecs[i], 1'b1, 0, $sformatf("row%0d", i));

    // Rewind while a read is in flight: its byte must be discarded.
    lat = 20;
    do_rewind(4);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cyc();
      seen = bus.sdram_rd && (bus.sdram_addr == ADDR_W'(1));
    end
    check("abort_req1_seen", seen, 1);
    repeat (5) cyc();
    rewind = 1'b1;
    epoch++;
    delivered = 0;
    cyc();
    rewind = 1'b0;
    tape_len = ADDR_W'(9);
    check("abort_status", status, 3'b001);
    check("abort_byte_pos", byte_pos, 0);
    check("abort_rd_held", bus.sdram_rd, 1);
    n0 = req_addr.size();
    stayed_empty = 1'b1;
    for (int i = 0; i < 200 && req_addr.size() <= n0; i++) begin
      cyc();
      if (!status[0]) stayed_empty = 1'b0;
    end
    check("abort_fifo_stays_empty", stayed_empty, 1);
    check("abort_new_req_made", req_addr.size() > n0, 1);
    if (req_addr.size() > n0) check("abort_restart_addr", req_addr[n0], 0);
    rv = '{len: 4, lat: 20, prefill: 0, ce_pct: 100, pause_k: -1, pause_len: 0, under_mode: 2};
    play_tape(rv, 1'b0, 0, "after_abort");

    // Empty tape goes straight to EOT and never reads.
    lat = 0;
    do_rewind(0);
    rd_cycles = 0;
    repeat (5) cyc();
    play_tgl = 1'b1;
    cyc();
    play_tgl = 1'b0;
    check("len0_status", status, 3'b011);
    repeat (10) cyc();
    check("len0_no_reads", rd_cycles, 0);
    check("len0_data", data, 0);

    // Asynchronous reset mid-play, then the length is taken at reset release.
    do_rewind(5);
    ce = 1'b1;
    repeat (20) cyc();
    play_tgl = 1'b1;
    cyc();
    play_tgl = 1'b0;
    repeat (30) cyc();
    check("pre_reset_playing", status[2], 1);
    #3 rst_n = 1'b0;
    rst_epoch++;
    epoch++;
    delivered = 0;
    #1;
    check("areset_status", status, 3'b001);
    check("areset_data", data, 0);
    check("areset_byte_pos", byte_pos, 0);
    check("areset_underruns", underruns, 0);
    check("areset_rd", bus.sdram_rd, 0);
    check("areset_addr", bus.sdram_addr, 0);
    tape_len = ADDR_W'(2);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    rv = '{len: 2, lat: 1, prefill: 10, ce_pct: 100, pause_k: -1, pause_len: 0, under_mode: 0};
    play_tape(rv, 1'b0, 0, "after_reset");

    // Random tapes, timing and pauses.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(255));
      rv.len        = $urandom_range(24, 1);
      rv.lat        = $urandom_range(20, 0);
      rv.prefill    = $urandom_range(20, 0);
      rv.ce_pct     = $urandom_range(100, 20);
      rv.pause_k    = -1;
      rv.pause_len  = 0;
      rv.under_mode = 2;
      play_tape(rv, 1'b1, $urandom_range(20, 0), $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
